// File: rtl/ehl_ahb_matrix_port.sv
// ehl_ahb_matrix_port: per-slave output stage of the AHB multi-layer matrix.
// Arbitrates the masters decoded to this slave, forwards the owner's address phase and routes the data phase back.
module ehl_ahb_matrix_port #(
  parameter int MNUM     = 4,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int ARB_MODE = 1
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [MNUM*AW-1:0]   im_haddr,
  input  logic [MNUM*2-1:0]    im_htrans,
  input  logic [MNUM-1:0]      im_hwrite,
  input  logic [MNUM*3-1:0]    im_hsize,
  input  logic [MNUM*3-1:0]    im_hburst,
  input  logic [MNUM*4-1:0]    im_hprot,
  input  logic [MNUM-1:0]      im_hmastlock,
  input  logic [MNUM*DW-1:0]   im_hwdata,
  output logic [DW-1:0]        om_hrdata,
  output logic [MNUM-1:0]      om_hready,
  output logic [MNUM*2-1:0]    om_hresp,
  output logic [AW-1:0]        os_haddr,
  output logic [1:0]           os_htrans,
  output logic                 os_hwrite,
  output logic [2:0]           os_hsize,
  output logic [2:0]           os_hburst,
  output logic [3:0]           os_hprot,
  output logic                 os_hmastlock,
  output logic [DW-1:0]        os_hwdata,
  output logic                 os_hsel,
  input  logic [DW-1:0]        is_hrdata,
  input  logic                 is_hready,
  input  logic [1:0]           is_hresp
);

  localparam int MW = (MNUM > 1) ? $clog2(MNUM) : 1;

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_SEQ  = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  generate
    if (MNUM < 1 || MNUM > 16) begin : g_bad_mnum
      $fatal(1, "ehl_ahb_matrix_port: MNUM must be 1..16");
    end
    if (DW != 32 && DW != 64) begin : g_bad_dw
      $fatal(1, "ehl_ahb_matrix_port: DW must be 32 or 64");
    end
  endgenerate

  typedef struct packed {
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic          hmastlock;
  } aphase_t;

  logic          own_v_q, own_v_d;
  logic [MW-1:0] own_m_q, own_m_d;
  logic          dp_v_q, dp_v_d;
  logic [MW-1:0] dp_m_q, dp_m_d;
  logic [MW-1:0] rr_last_q, rr_last_d;

  logic [MNUM-1:0] req;
  aphase_t         own_aph;
  logic [DW-1:0]   dp_wdata;
  logic            arb_open;
  logic            accept;
  logic            win_v;
  logic [MW-1:0]   win_m;

  function automatic logic [MW-1:0] rr_index(input logic [MW-1:0] base, input int offset);
    int k;
    k = int'(base) + offset;
    if (k >= MNUM) k = k - MNUM;
    return MW'(k);
  endfunction

  // Owner's address phase; all-zero (IDLE) when nobody owns the port.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req      = '0;
    own_aph  = '0;
    dp_wdata = '0;
    for (int m = 0; m < MNUM; m++) begin
      req[m] = im_htrans[2*m+1];
      if (own_v_q && own_m_q == MW'(m)) begin
        own_aph.haddr     = im_haddr[m*AW +: AW];
        own_aph.htrans    = im_htrans[m*2 +: 2];
        own_aph.hwrite    = im_hwrite[m];
        own_aph.hsize     = im_hsize[m*3 +: 3];
        own_aph.hburst    = im_hburst[m*3 +: 3];
        own_aph.hprot     = im_hprot[m*4 +: 4];
        own_aph.hmastlock = im_hmastlock[m];
      end
      if (dp_v_q && dp_m_q == MW'(m)) begin
        dp_wdata = im_hwdata[m*DW +: DW];
      end
    end
  end

  // Bursts in progress (SEQ/BUSY) and locked sequences keep the port.
  assign arb_open = is_hready &&
                    !(own_aph.htrans == HT_SEQ || own_aph.htrans == HT_BUSY || own_aph.hmastlock);
  assign accept   = own_v_q && own_aph.htrans[1] && is_hready;

  // Iterate from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_v = 1'b0;
    win_m = '0;
    if (ARB_MODE == 0) begin
      for (int m = MNUM - 1; m >= 0; m--) begin
        if (req[m]) begin
          win_v = 1'b1;
          win_m = MW'(m);
        end
      end
    end else begin
      for (int i = MNUM; i >= 1; i--) begin
        if (req[rr_index(rr_last_q, i)]) begin
          win_v = 1'b1;
          win_m = rr_index(rr_last_q, i);
        end
      end
    end
  end

  always_comb begin
    own_v_d   = own_v_q;
    own_m_d   = own_m_q;
    rr_last_d = rr_last_q;
    dp_v_d    = dp_v_q;
    dp_m_d    = dp_m_q;
    if (arb_open && win_v) begin
      own_v_d   = 1'b1;
      own_m_d   = win_m;
      rr_last_d = win_m;
    end
    if (accept) begin
      dp_v_d = 1'b1;
      dp_m_d = own_m_q;
    end else if (is_hready) begin
      dp_v_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only control state is reset; the data paths are pure muxes with no storage of their own.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      own_v_q   <= 1'b0;
      own_m_q   <= '0;
      dp_v_q    <= 1'b0;
      dp_m_q    <= '0;
      rr_last_q <= MW'(MNUM - 1);
    end else begin
      own_v_q   <= own_v_d;
      own_m_q   <= own_m_d;
      dp_v_q    <= dp_v_d;
      dp_m_q    <= dp_m_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign os_haddr     = own_aph.haddr;
  assign os_htrans    = own_aph.htrans;
  assign os_hwrite    = own_aph.hwrite;
  assign os_hsize     = own_aph.hsize;
  assign os_hburst    = own_aph.hburst;
  assign os_hprot     = own_aph.hprot;
  assign os_hmastlock = own_aph.hmastlock;
  assign os_hsel      = own_v_q;
  assign os_hwdata    = dp_wdata;
  assign om_hrdata    = is_hrdata;

  // Data-phase master sees the slave; other requesters stall until they own the address phase.
  always_comb begin
    om_hready = '1;
    om_hresp  = {MNUM{RESP_OKAY}};
    for (int m = 0; m < MNUM; m++) begin
      if (dp_v_q && dp_m_q == MW'(m)) begin
        om_hready[m]       = is_hready;
        om_hresp[m*2 +: 2] = is_hresp;
      end else if (req[m] && !(own_v_q && own_m_q == MW'(m))) begin
        om_hready[m] = 1'b0;
      end else if (req[m]) begin
        om_hready[m] = is_hready;
      end
    end
  end

  logic unused_idle;
  assign unused_idle = (HT_IDLE == 2'b00);

endmodule
